// File: rtl/axp_lsu.sv
// AXP load/store unit: decodes one memory instruction, runs a single data-bus
// transaction, and returns the aligned and extended load result or a fault code.
module axp_lsu #(
  parameter bit BWX = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] cmd,
  input  logic [63:0] addr,
  input  logic [7:0]  mask,
  input  logic [63:0] wdata,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic        mem_we,
  output logic [60:0] mem_addr,
  output logic [7:0]  mem_be,
  output logic [63:0] mem_wdata,
  input  logic        mem_rvalid,
  input  logic [63:0] mem_rdata,
  output logic        rsp_valid,
  output logic [63:0] rsp_data,
  output logic [1:0]  rsp_fault
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

  localparam logic [5:0] OP_LDBU  = 6'h0A;
  localparam logic [5:0] OP_LDQ_U = 6'h0B;
  localparam logic [5:0] OP_LDWU  = 6'h0C;
  localparam logic [5:0] OP_STW   = 6'h0D;
  localparam logic [5:0] OP_STB   = 6'h0E;
  localparam logic [5:0] OP_STQ_U = 6'h0F;
  localparam logic [5:0] OP_LDL   = 6'h28;
  localparam logic [5:0] OP_LDQ   = 6'h29;
  localparam logic [5:0] OP_STL   = 6'h2C;
  localparam logic [5:0] OP_STQ   = 6'h2D;

  localparam logic [1:0] FAULT_NONE    = 2'd0;
  localparam logic [1:0] FAULT_UNALIGN = 2'd1;
  localparam logic [1:0] FAULT_ILLEGAL = 2'd2;

  state_t      state;
  logic        is_store;
  logic        is_ldl;
  logic [2:0]  off_r;
  logic [7:0]  mask_r;

  logic [5:0]  op;
  logic        dec_load;
  logic        dec_store;
  logic        dec_quad_u;
  logic        dec_illegal;
  logic        dec_unaligned;
  logic [2:0]  size_m1;
  logic [2:0]  dec_off;
  logic [7:0]  dec_be;
  logic [63:0] dec_wdata;
  logic [63:0] shifted;
  logic [63:0] extracted;
  logic [63:0] load_result;

  // Only the opcode field of the instruction word matters here.
  logic unused_cmd;
  assign unused_cmd = ^cmd[25:0];

  function automatic logic [63:0] bytemask(input logic [7:0] m);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = {8{m[i]}};
    return r;
  endfunction

  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    op         = cmd[31:26];
    dec_load   = 1'b0;
    dec_store  = 1'b0;
    dec_quad_u = 1'b0;
    case (op)
      OP_LDBU, OP_LDWU: dec_load  = BWX;
      OP_STW, OP_STB:   dec_store = BWX;
      OP_LDL, OP_LDQ:   dec_load  = 1'b1;
      OP_STL, OP_STQ:   dec_store = 1'b1;
      OP_LDQ_U: begin
        dec_load   = 1'b1;
        dec_quad_u = 1'b1;
      end
      OP_STQ_U: begin
        dec_store  = 1'b1;
        dec_quad_u = 1'b1;
      end
      default: ;
    endcase
    dec_illegal   = !(dec_load || dec_store);
    size_m1       = 3'($countones(mask) - 1);
    dec_unaligned = !dec_quad_u && ((addr[2:0] & size_m1) != 3'b000);
    dec_off       = dec_quad_u ? 3'b000 : addr[2:0];
    dec_be        = dec_quad_u ? 8'hFF : 8'(mask << dec_off);
    dec_wdata     = wdata << {dec_off, 3'b000};
  end

  // Load path: bring the addressed lanes down to bit 0 and trim to the access size.
  always_comb begin
    shifted     = mem_rdata >> {off_r, 3'b000};
    extracted   = shifted & bytemask(mask_r);
    load_result = is_ldl ? {{32{extracted[31]}}, extracted[31:0]} : extracted;
  end

  // NOTE: datapath registers are reset too, because every output has a defined reset value.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_IDLE;
      req_ready <= 1'b1;
      mem_valid <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_fault <= FAULT_NONE;
      is_store  <= 1'b0;
      is_ldl    <= 1'b0;
      off_r     <= '0;
      mask_r    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            is_store  <= dec_store;
            is_ldl    <= (op == OP_LDL);
            off_r     <= dec_off;
            mask_r    <= mask;
            if (dec_illegal || dec_unaligned) begin
              state     <= S_RESP;
              rsp_valid <= 1'b1;
              rsp_data  <= '0;
              rsp_fault <= dec_illegal ? FAULT_ILLEGAL : FAULT_UNALIGN;
            end else begin
              state     <= S_REQ;
              mem_valid <= 1'b1;
              mem_we    <= dec_store;
              mem_addr  <= addr[63:3];
              mem_be    <= dec_be;
              mem_wdata <= dec_wdata;
            end
          end
        end
        S_REQ: begin
          if (mem_ready) begin
            mem_valid <= 1'b0;
            mem_we    <= 1'b0;
            if (is_store) begin
              state     <= S_RESP;
              rsp_valid <= 1'b1;
              rsp_data  <= '0;
              rsp_fault <= FAULT_NONE;
            end else begin
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (mem_rvalid) begin
            state     <= S_RESP;
            rsp_valid <= 1'b1;
            rsp_data  <= load_result;
            rsp_fault <= FAULT_NONE;
          end
        end
        S_RESP: begin
          state     <= S_IDLE;
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axp_lsu.sv
// Directed bench for axp_lsu: a vector table of single transactions plus
// hand-written sequences for bus stalls, reset mid-load and the BWX=0 variant.
module tb_axp_lsu;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] cmd;
  logic [63:0] addr;
  logic [7:0]  mask;
  logic [63:0] wdata;
  logic        mem_valid;
  logic        mem_ready;
  logic        mem_we;
  logic [60:0] mem_addr;
  logic [7:0]  mem_be;
  logic [63:0] mem_wdata;
  logic        mem_rvalid;
  logic [63:0] mem_rdata;
  logic        rsp_valid;
  logic [63:0] rsp_data;
  logic [1:0]  rsp_fault;

  logic        nb_req_ready;
  logic        nb_mem_valid;
  logic        nb_mem_we;
  logic [60:0] nb_mem_addr;
  logic [7:0]  nb_mem_be;
  logic [63:0] nb_mem_wdata;
  logic        nb_rsp_valid;
  logic [63:0] nb_rsp_data;
  logic [1:0]  nb_rsp_fault;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clock = ~clock;

  axp_lsu #(.BWX(1'b1)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .cmd(cmd), .addr(addr), .mask(mask), .wdata(wdata),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_fault(rsp_fault)
  );

  axp_lsu #(.BWX(1'b0)) dut_nobwx (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(nb_req_ready),
    .cmd(cmd), .addr(addr), .mask(mask), .wdata(wdata),
    .mem_valid(nb_mem_valid), .mem_ready(mem_ready), .mem_we(nb_mem_we),
    .mem_addr(nb_mem_addr), .mem_be(nb_mem_be), .mem_wdata(nb_mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .rsp_valid(nb_rsp_valid), .rsp_data(nb_rsp_data), .rsp_fault(nb_rsp_fault)
  );

  typedef struct {
    logic [5:0]  op;
    logic [63:0] addr;
    logic [7:0]  mask;
    logic [63:0] wdata;
    logic [63:0] rdata;
    logic        store;
    logic [1:0]  fault;
    logic [7:0]  be;
    logic [63:0] bus_wdata;
    logic [63:0] result;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic offer(input logic [5:0] op, input logic [63:0] a, input logic [7:0] m,
                       input logic [63:0] wd);
    req_valid = 1'b1;
    cmd       = {op, 26'h2AB_CDEF};
    addr      = a;
    mask      = m;
    wdata     = wd;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    string t;
    t = $sformatf("v%0d", idx);
    offer(v.op, v.addr, v.mask, v.wdata);
    check({t, " busy"}, 64'(req_ready), 64'd0);
    if (v.fault != 2'd0) begin
      check({t, " fault rsp_valid"}, 64'(rsp_valid), 64'd1);
      check({t, " fault code"}, 64'(rsp_fault), 64'(v.fault));
      check({t, " fault data"}, rsp_data, 64'd0);
      check({t, " fault no bus"}, 64'(mem_valid), 64'd0);
      tick();
      check({t, " fault idle"}, 64'({req_ready, rsp_valid, mem_valid}), 64'b100);
    end else begin
      check({t, " mem_valid"}, 64'(mem_valid), 64'd1);
      check({t, " mem_we"}, 64'(mem_we), 64'(v.store));
      check({t, " mem_addr"}, 64'(mem_addr), {3'b000, v.addr[63:3]});
      check({t, " mem_be"}, 64'(mem_be), 64'(v.be));
      check({t, " mem_wdata"}, mem_wdata, v.bus_wdata);
      mem_ready  = 1'b1;
      mem_rvalid = 1'b1;
      mem_rdata  = 64'h5A5A_5A5A_5A5A_5A5A;
      tick();
      mem_ready  = 1'b0;
      mem_rvalid = 1'b0;
      check({t, " mem_valid drop"}, 64'(mem_valid), 64'd0);
      if (!v.store) begin
        check({t, " wait no rsp"}, 64'(rsp_valid), 64'd0);
        mem_rvalid = 1'b1;
        mem_rdata  = v.rdata;
        tick();
        mem_rvalid = 1'b0;
      end
      check({t, " rsp_valid"}, 64'(rsp_valid), 64'd1);
      check({t, " rsp_fault"}, 64'(rsp_fault), 64'd0);
      check({t, " rsp_data"}, rsp_data, v.result);
      tick();
      check({t, " idle"}, 64'({req_ready, rsp_valid}), 64'b10);
    end
  endtask

  initial begin
    vec_t vecs[15];
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[15];
    //         op     addr                     mask   wdata                    rdata                    st fault be     bus_wdata                result
    vecs[0]  = '{6'h28, 64'h0000_0010_0000_1004, 8'h0F, 64'h0,                  64'h8000_0001_1234_5678, 1'b0, 2'd0, 8'hF0, 64'h0,                  64'hFFFF_FFFF_8000_0001};
    vecs[1]  = '{6'h0E, 64'h0000_0000_0000_2003, 8'h01, 64'hAB,                  64'h0,                   1'b1, 2'd0, 8'h08, 64'h0000_0000_AB00_0000, 64'h0};
    vecs[2]  = '{6'h29, 64'h0000_0000_0000_3004, 8'hFF, 64'h0,                   64'h0,                   1'b0, 2'd1, 8'h00, 64'h0,                  64'h0};
    vecs[3]  = '{6'h0B, 64'h0000_0000_0000_3004, 8'hFF, 64'h0,                   64'h0123_4567_89AB_CDEF, 1'b0, 2'd0, 8'hFF, 64'h0,                  64'h0123_4567_89AB_CDEF};
    vecs[4]  = '{6'h11, 64'h0000_0000_0000_4000, 8'hFF, 64'h0,                   64'h0,                   1'b0, 2'd2, 8'h00, 64'h0,                  64'h0};
    vecs[5]  = '{6'h0C, 64'h0000_0000_0000_5006, 8'h03, 64'h0,                   64'hBEEF_1122_3344_5566, 1'b0, 2'd0, 8'hC0, 64'h0,                  64'h0000_0000_0000_BEEF};
    vecs[6]  = '{6'h2D, 64'hFFFF_FFFF_FFFF_FFF8, 8'hFF, 64'hDEAD_BEEF_CAFE_F00D, 64'h0,                   1'b1, 2'd0, 8'hFF, 64'hDEAD_BEEF_CAFE_F00D, 64'h0};
    vecs[7]  = '{6'h0D, 64'h0000_0000_0000_6002, 8'h03, 64'h1234,                64'h0,                   1'b1, 2'd0, 8'h0C, 64'h0000_0000_1234_0000, 64'h0};
    vecs[8]  = '{6'h2C, 64'h0000_0000_0000_7005, 8'h0F, 64'h5555,                64'h0,                   1'b1, 2'd1, 8'h00, 64'h0,                  64'h0};
    vecs[9]  = '{6'h0A, 64'h0000_0000_0000_8007, 8'h01, 64'h0,                   64'h9A11_2233_4455_6677, 1'b0, 2'd0, 8'h80, 64'h0,                  64'h0000_0000_0000_009A};
    vecs[10] = '{6'h0F, 64'h0000_0000_0000_9005, 8'hFF, 64'h1122_3344_5566_7788, 64'h0,                   1'b1, 2'd0, 8'hFF, 64'h1122_3344_5566_7788, 64'h0};
    vecs[11] = '{6'h28, 64'h0000_0000_0000_A000, 8'h0F, 64'h0,                   64'hFFFF_FFFF_7FFF_FFFF, 1'b0, 2'd0, 8'h0F, 64'h0,                  64'h0000_0000_7FFF_FFFF};
    vecs[12] = '{6'h29, 64'h0000_0000_0000_B008, 8'hFF, 64'h0,                   64'hFEDC_BA98_7654_3210, 1'b0, 2'd0, 8'hFF, 64'h0,                  64'hFEDC_BA98_7654_3210};
    vecs[13] = '{6'h0C, 64'h0000_0000_0000_0001, 8'h03, 64'h0,                   64'h0,                   1'b0, 2'd1, 8'h00, 64'h0,                  64'h0};
    vecs[14] = '{6'h0A, 64'h0000_0000_0000_C002, 8'h01, 64'h77,                  64'h0000_0000_00C3_0000, 1'b0, 2'd0, 8'h04, 64'h0000_0000_0077_0000, 64'h0000_0000_0000_00C3};

    reset      = 1'b1;
    req_valid  = 1'b0;
    cmd        = '0;
    addr       = '0;
    mask       = '0;
    wdata      = '0;
    mem_ready  = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    repeat (2) tick();
    reset = 1'b0;
    tick();

    check("reset req_ready", 64'(req_ready), 64'd1);
    check("reset mem_valid", 64'(mem_valid), 64'd0);
    check("reset rsp_valid", 64'(rsp_valid), 64'd0);
    check("reset mem_be", 64'(mem_be), 64'd0);
    check("reset rsp_fault", 64'(rsp_fault), 64'd0);

    for (int i = 0; i < 15; i++) run_vec(i, vecs[i]);

    // stb stalled by the bus for three cycles: request must hold steady.
    offer(6'h0E, 64'h0000_0000_0000_2003, 8'h01, 64'hAB);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("stall%0d mem_valid", i), 64'(mem_valid), 64'd1);
      check($sformatf("stall%0d mem_be", i), 64'(mem_be), 64'h08);
      check($sformatf("stall%0d mem_wdata", i), mem_wdata, 64'h0000_0000_AB00_0000);
      check($sformatf("stall%0d no rsp", i), 64'(rsp_valid), 64'd0);
      if (i == 3) mem_ready = 1'b1;
      tick();
    end
    mem_ready = 1'b0;
    check("stall rsp_valid", 64'(rsp_valid), 64'd1);
    check("stall mem_valid drop", 64'(mem_valid), 64'd0);
    tick();
    check("stall rsp pulse", 64'(rsp_valid), 64'd0);
    check("stall idle", 64'(req_ready), 64'd1);

    // Reset while waiting for load data: the late data must be discarded.
    offer(6'h29, 64'h0000_0000_0000_D008, 8'hFF, 64'h0);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 64'h1111_2222_3333_4444;
    tick();
    mem_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rstwait%0d rsp_valid", i), 64'(rsp_valid), 64'd0);
      check($sformatf("rstwait%0d req_ready", i), 64'(req_ready), 64'd1);
      tick();
    end
    check("rstwait mem_valid", 64'(mem_valid), 64'd0);
    check("rstwait mem_addr", 64'(mem_addr), 64'd0);
    check("rstwait mem_be", 64'(mem_be), 64'd0);
    check("rstwait mem_wdata", mem_wdata, 64'd0);
    check("rstwait rsp_data", rsp_data, 64'd0);
    check("rstwait rsp_fault", 64'(rsp_fault), 64'd0);

    // ldbu without the byte/word extension is illegal; with it, a normal load.
    offer(6'h0A, 64'h0000_0000_0000_E001, 8'h01, 64'h0);
    check("nobwx rsp_valid", 64'(nb_rsp_valid), 64'd1);
    check("nobwx fault", 64'(nb_rsp_fault), 64'd2);
    check("nobwx data", nb_rsp_data, 64'd0);
    check("nobwx no bus", 64'({nb_mem_valid, nb_mem_we, nb_mem_be}), 64'd0);
    check("nobwx bus regs", {3'b000, nb_mem_addr} | nb_mem_wdata, 64'd0);
    check("bwx mem_valid", 64'(mem_valid), 64'd1);
    check("bwx mem_be", 64'(mem_be), 64'h02);
    mem_ready = 1'b1;
    tick();
    mem_ready  = 1'b0;
    check("nobwx back idle", 64'(nb_req_ready), 64'd1);
    mem_rvalid = 1'b1;
    mem_rdata  = 64'h0000_0000_0000_E700;
    tick();
    mem_rvalid = 1'b0;
    check("bwx rsp_data", rsp_data, 64'h0000_0000_0000_00E7);
    check("bwx rsp_valid", 64'(rsp_valid), 64'd1);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/axp_lsu.md
# axp_lsu

Load/store unit that carries an AXP memory instruction from effective address to data bus and back. It takes the instruction word, the effective address and the byte-size mask produced by the address stage (opcodes 0A-0F, 28/29/2C/2D), and runs one bus transaction. For stores it places data on byte lanes; for loads it extracts and extends the returned quadword. It sits between the execute stage and the data-memory port and holds one access in flight.

## Interface
- BWX, 1, byte/word extension present; when 0, opcodes 0A/0C/0D/0E are illegal
- clock  in  1  clock; all state changes on rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  1  access offered by execute stage
- req_ready  out  1  unit idle and able to accept; reset 1
- cmd  in  32  instruction word; opcode is cmd[31:26]
- addr  in  64  effective address (base + disp)
- mask  in  8  size mask: 01 byte, 03 word, 0F long, FF quad
- wdata  in  64  store data (Ra), right-justified
- mem_valid  out  1  bus request; reset 0
- mem_ready  in  1  bus accepts request
- mem_we  out  1  1 = write; reset 0
- mem_addr  out  61  quadword address addr[63:3]; reset 0
- mem_be  out  8  byte enables; reset 0
- mem_wdata  out  64  lane-aligned write data; reset 0
- mem_rvalid  in  1  read data valid
- mem_rdata  in  64  read quadword
- rsp_valid  out  1  one-cycle completion pulse; reset 0
- rsp_data  out  64  load result, 0 for stores and faults; reset 0
- rsp_fault  out  2  0 ok, 1 unaligned, 2 illegal opcode; reset 0

## Operation
- States: IDLE, REQ, WAIT, RESP. Reset -> IDLE.
- IDLE: req_ready=1. On req_valid, latch cmd opcode, addr, mask, wdata; classify:
  - loads 0A ldbu, 0B ldq_u, 0C ldwu, 28 ldl, 29 ldq; stores 0D stw, 0E stb, 0F stq_u, 2C stl, 2D stq; anything else illegal.
  - illegal -> RESP, fault 2. Unaligned (addr[2:0] & (size-1) != 0, size = popcount(mask)) for any except 0B/0F -> RESP, fault 1. No bus activity on fault.
  - otherwise -> REQ.
- 0B/0F: offset forced to 0 (addr[2:0] ignored), be = FF.
- REQ: mem_valid=1, mem_addr=addr[63:3], mem_be = mask << off, mem_wdata = wdata << 8*off, mem_we=store. Outputs stable until mem_ready. On mem_ready: store -> RESP; load -> WAIT.
- WAIT: on mem_rvalid, x = (mem_rdata >> 8*off) & bytemask(mask); ldl: rsp_data = sext32(x[31:0]); ldbu/ldwu/ldq/ldq_u: zero-extend x. -> RESP.
- RESP: rsp_valid=1 for exactly one cycle with rsp_data/rsp_fault; -> IDLE. rsp_data/rsp_fault hold until next RESP.
- mem_rvalid outside WAIT ignored. mem_ready outside REQ ignored.

## Timing
- Request accepted at edge N (req_valid & req_ready); mem_valid high from cycle N+1.
- Fault: rsp_valid in cycle N+1; req_ready again in N+2.
- Store with mem_ready in first REQ cycle: rsp_valid in N+2; idle N+3.
- Load: memory returns mem_rvalid no earlier than the cycle after the mem_ready handshake; rvalid at cycle M -> rsp_valid at M+1.
- No back-to-back issue: req_ready=0 from N+1 until return to IDLE.
- Reset in any state: next cycle IDLE, mem_valid=0, rsp_valid=0, all outputs at reset values; pending bus data discarded.

## Test plan
- ldl (28), addr=...1004, mask 0F, mem_rdata=8000_0001_xxxx_xxxx -> mem_be=F0, rsp_data=FFFF_FFFF_8000_0001, fault 0.
- stb (0E), addr=...0003, wdata=...AB, mem_ready held low 3 cycles -> mem_valid/mem_be=08/mem_wdata=0000_0000_AB00_0000 stable 4 cycles, rsp_valid one cycle later.
- ldq (29), addr=...0004 -> no mem_valid, rsp_valid N+1, rsp_fault=1; ldq_u (0B) same addr -> mem_be=FF, rsp_data=mem_rdata.
- opcode 11 or BWX=0 with ldbu -> rsp_fault=2, no bus request; ldwu addr=...0006 with BWX=1, rdata=BEEF_xxxx_xxxx_xxxx -> rsp_data=0000_..._BEEF.
- reset asserted in WAIT, then mem_rvalid -> no rsp_valid, req_ready=1, all outputs at reset values.
